// File: rtl/input_pkg.sv
// rtl/input_pkg.sv - shared key indices, 50 MHz timing defaults and repeat FSM states
package input_pkg;

   localparam int KEY_LEFT  = 0;
   localparam int KEY_RIGHT = 1;
   localparam int KEY_ROT   = 2;
   localparam int KEY_DROP  = 3;

   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_DAS_DELAY       = 10000000;
   localparam int DEF_DAS_RATE        = 2500000;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rpt_state_e;

   // Counter width for a modulus n; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - per-key debounce, press detect and auto-repeat timer
// Auto-repeat FSM exists only when KEY_REPEAT_EN is defined and REPEAT_EN is set.
module key_channel
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DAS_DELAY       = DEF_DAS_DELAY,
   parameter int DAS_RATE        = DEF_DAS_RATE,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic repeat_o
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);

   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic          level_q, level_d;
   logic          prev_q;

   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (key_i != level_q) begin
         if (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         prev_q   <= 1'b0;
      end else begin
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         prev_q   <= level_q;
      end
   end

   assign level_o = level_q;
   assign press_o = level_q & ~prev_q;

   logic unused_cfg;
   assign unused_cfg = ^{32'(DAS_DELAY), 32'(DAS_RATE), REPEAT_EN};

`ifdef KEY_REPEAT_EN
   generate
      if (REPEAT_EN) begin : g_rpt
         localparam int TW = cnt_width((DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE);

         rpt_state_e    state_q, state_d;
         logic [TW-1:0] timer_q, timer_d;
         logic          tick;

         always_comb begin
            state_d = state_q;
            timer_d = timer_q + 1'b1;
            tick    = 1'b0;
            case (state_q)
               IDLE: begin
                  timer_d = '0;
                  if (press_o) state_d = DELAY;
               end
               DELAY: begin
                  if (timer_q == TW'(DAS_DELAY - 1)) begin
                     tick    = 1'b1;
                     state_d = REPEAT;
                     timer_d = '0;
                  end
               end
               REPEAT: begin
                  if (timer_q == TW'(DAS_RATE - 1)) begin
                     tick    = 1'b1;
                     timer_d = '0;
                  end
               end
               default: begin
                  state_d = IDLE;
                  timer_d = '0;
               end
            endcase
            // A released key never ticks, whatever the timer says.
            if (!level_q) begin
               state_d = IDLE;
               timer_d = '0;
               tick    = 1'b0;
            end
         end

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               state_q <= IDLE;
               timer_q <= '0;
            end else begin
               state_q <= state_d;
               timer_q <= timer_d;
            end
         end

         assign repeat_o = tick;
      end else begin : g_no_rpt
         assign repeat_o = 1'b0;
      end
   endgenerate
`else
   assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/key_input_scheduler.sv
// rtl/key_input_scheduler.sv - debounced key events arbitrated onto one valid/ready command stream
// KEY_REPEAT_EN enables DAS auto-repeat; without it only fresh presses become commands.
module key_input_scheduler
   import input_pkg::*;
#(
   parameter int               N_KEYS          = 4,
   parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int               DAS_DELAY       = DEF_DAS_DELAY,
   parameter int               DAS_RATE        = DEF_DAS_RATE,
   parameter logic [N_KEYS-1:0] REPEAT_MASK    = N_KEYS'(4'b0011)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_sync,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [N_KEYS-1:0] cmd_key,
   output logic              cmd_repeat,
   output logic [N_KEYS-1:0] key_state
);

`ifdef KEY_REPEAT_EN
   localparam bit RPT_ON = 1'b1;
`else
   localparam bit RPT_ON = 1'b0;
`endif

   logic [N_KEYS-1:0] press, rpt;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      key_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .DAS_DELAY       (DAS_DELAY),
         .DAS_RATE        (DAS_RATE),
         .REPEAT_EN       (REPEAT_MASK[i] & RPT_ON)
      ) u_chan (
         .clk_i    (clock),
         .rst_i    (reset),
         .key_i    (key_sync[i]),
         .level_o  (key_state[i]),
         .press_o  (press[i]),
         .repeat_o (rpt[i])
      );
   end

   logic [N_KEYS-1:0] pend_q, pend_d, pend_rep_q, pend_rep_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [N_KEYS-1:0] cmd_key_q, cmd_key_d;
   logic              cmd_repeat_q, cmd_repeat_d;
   logic [N_KEYS-1:0] sel, take;
   logic              sel_rep, found, free;

   always_comb begin
      sel     = '0;
      sel_rep = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < N_KEYS; i++) begin
         if (!found && pend_q[i]) begin
            found   = 1'b1;
            sel[i]  = 1'b1;
            sel_rep = pend_rep_q[i] & RPT_ON;
         end
      end

      free         = !cmd_valid_q || cmd_ready;
      cmd_valid_d  = cmd_valid_q;
      cmd_key_d    = cmd_key_q;
      cmd_repeat_d = cmd_repeat_q;
      take         = '0;
      if (free) begin
         cmd_valid_d  = found;
         cmd_key_d    = sel;
         cmd_repeat_d = sel_rep;
         take         = sel;
      end

      // A new event on the key being granted re-arms its flag: set beats clear.
      pend_d = (pend_q & ~take) | press | rpt;
      for (int i = 0; i < N_KEYS; i++) begin
         pend_rep_d[i] = rpt[i] ? 1'b1 : (press[i] ? 1'b0 : pend_rep_q[i]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pend_q       <= '0;
         pend_rep_q   <= '0;
         cmd_valid_q  <= 1'b0;
         cmd_key_q    <= '0;
         cmd_repeat_q <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_rep_q   <= pend_rep_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_key_q    <= cmd_key_d;
         cmd_repeat_q <= cmd_repeat_d;
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_key    = cmd_key_q;
   assign cmd_repeat = cmd_repeat_q;

endmodule

// File: tb/tb_key_input_scheduler.sv
// tb/tb_key_input_scheduler.sv - directed bench; repeat scenarios follow KEY_REPEAT_EN
module tb_key_input_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] key_sync = 4'b0000;
   logic       cmd_ready = 1'b0;
   logic       cmd_valid;
   logic [3:0] cmd_key;
   logic       cmd_repeat;
   logic [3:0] key_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   key_input_scheduler #(
      .N_KEYS          (4),
      .DEBOUNCE_CYCLES (4),
      .DAS_DELAY       (10),
      .DAS_RATE        (3),
      .REPEAT_MASK     (4'b0011)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .key_sync   (key_sync),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_key    (cmd_key),
      .cmd_repeat (cmd_repeat),
      .key_state  (key_state)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int  cnt;
      bit  ev;

      // reset state
      reset = 1'b1;
      step(3);
      chk("rst_valid", cmd_valid, 0);
      chk("rst_key", cmd_key, 0);
      chk("rst_repeat", cmd_repeat, 0);
      chk("rst_state", key_state, 0);
      reset = 1'b0;
      step(1);

      // glitch of 3 cycles is rejected
      key_sync = 4'b0100;
      step(3);
      key_sync = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("glitch_state", key_state, 0);
         chk("glitch_valid", cmd_valid, 0);
      end

      // 6-cycle press: accepted after 4 stable cycles, command 2 cycles later
      cmd_ready = 1'b1;
      key_sync  = 4'b0100;
      step(3);
      chk("db_state_early", key_state, 4'b0000);
      step(1);
      chk("db_state", key_state, 4'b0100);
      step(1);
      chk("db_valid_early", cmd_valid, 0);
      step(1);
      chk("db_valid", cmd_valid, 1);
      chk("db_key", cmd_key, 4'b0100);
      chk("db_repeat", cmd_repeat, 0);
      key_sync = 4'b0000;
      step(1);
      chk("db_drained", cmd_valid, 0);
      step(8);
      chk("db_released", key_state, 0);
      chk("db_no_release_cmd", cmd_valid, 0);

      // priority: keys 1 and 3 together
      key_sync = 4'b1010;
      step(4);
      chk("prio_state", key_state, 4'b1010);
      step(2);
      chk("prio_valid0", cmd_valid, 1);
      chk("prio_key0", cmd_key, 4'b0010);
      step(1);
      chk("prio_valid1", cmd_valid, 1);
      chk("prio_key1", cmd_key, 4'b1000);
      step(1);
      chk("prio_done", cmd_valid, 0);
      key_sync = 4'b0000;
      for (int i = 0; i < 12; i++) begin
         step(1);
         chk("prio_quiet", cmd_valid, 0);
      end
      chk("prio_released", key_state, 0);

`ifdef KEY_REPEAT_EN
      // auto-repeat: press at 6, first repeat at 16, then every 3 cycles
      key_sync = 4'b0001;
      for (int i = 1; i <= 24; i++) begin
         step(1);
         ev = (i == 6) || (i == 16) || (i == 19) || (i == 22);
         chk($sformatf("rpt_valid_%0d", i), cmd_valid, ev);
         if (ev) begin
            chk($sformatf("rpt_key_%0d", i), cmd_key, 4'b0001);
            chk($sformatf("rpt_type_%0d", i), cmd_repeat, (i != 6));
         end
      end
      key_sync = 4'b0000;
      for (int i = 25; i <= 40; i++) begin
         step(1);
         ev = (i == 25) || (i == 28);
         chk($sformatf("rel_valid_%0d", i), cmd_valid, ev);
         if (ev) chk($sformatf("rel_type_%0d", i), cmd_repeat, 1);
      end

      // backpressure: press held stable while repeats merge into one pending flag
      cmd_ready = 1'b0;
      key_sync  = 4'b0001;
      for (int i = 1; i <= 26; i++) begin
         step(1);
         if (i < 6) begin
            chk("bp_idle", cmd_valid, 0);
         end else begin
            chk($sformatf("bp_valid_%0d", i), cmd_valid, 1);
            chk($sformatf("bp_key_%0d", i), cmd_key, 4'b0001);
            chk($sformatf("bp_type_%0d", i), cmd_repeat, 0);
         end
         if (i == 20) key_sync = 4'b0000;
      end
      cmd_ready = 1'b1;
      step(1);
      chk("bp_merged_valid", cmd_valid, 1);
      chk("bp_merged_key", cmd_key, 4'b0001);
      chk("bp_merged_type", cmd_repeat, 1);
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("bp_after", cmd_valid, 0);
      end
`else
      // no auto-repeat: a 50-cycle hold yields exactly one press command
      key_sync = 4'b0001;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (cmd_valid) begin
            cnt++;
            chk("norpt_key", cmd_key, 4'b0001);
            chk("norpt_type", cmd_repeat, 0);
         end
      end
      chk("norpt_count", cnt, 1);
      key_sync = 4'b0000;
      step(10);
`endif

      // reset with a command held, then re-debounce of a still-held key
      cmd_ready = 1'b0;
      key_sync  = 4'b0001;
      step(20);
      chk("mid_valid", cmd_valid, 1);
      reset = 1'b1;
      step(1);
      chk("mid_rst_valid", cmd_valid, 0);
      chk("mid_rst_key", cmd_key, 0);
      chk("mid_rst_repeat", cmd_repeat, 0);
      chk("mid_rst_state", key_state, 0);
      reset = 1'b0;
      step(3);
      chk("re_db_early", key_state, 0);
      step(1);
      chk("re_db_state", key_state, 4'b0001);
      cmd_ready = 1'b1;
      step(2);
      chk("re_valid", cmd_valid, 1);
      chk("re_key", cmd_key, 4'b0001);
      chk("re_type", cmd_repeat, 0);
      key_sync = 4'b0000;
      step(30);
      chk("final_idle", cmd_valid, 0);
      chk("final_state", key_state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
